// File: rtl/seq_chunk_adder_if.sv
// Operand/result bundle for seq_chunk_adder. The requester drives the master side,
// and the adder implements the slave side.
`timescale 1ns/1ps

interface seq_chunk_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor. Each clock, a CHUNK-bit ripple slice adds
// one chunk, and a register carries the carry into the next chunk.
`timescale 1ns/1ps

module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clock,
    input  logic             resetn,
    seq_chunk_adder_if.slave bus
);
    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [CHUNK:0]   slice;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_co;
    logic             msb_ci;

    // Ripple slice over the low chunk of the shifting operands.
    always_comb begin
        slice = {1'b0, opa_q[CHUNK-1:0]} + {1'b0, opb_q[CHUNK-1:0]}
              + {{CHUNK{1'b0}}, carry_q};
    end

    assign slice_sum = slice[CHUNK-1:0];
    assign slice_co  = slice[CHUNK];
    // The carry into the slice MSB is recovered from the sum bit and its two addend bits.
    assign msb_ci    = slice_sum[CHUNK-1] ^ opa_q[CHUNK-1] ^ opb_q[CHUNK-1];

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    opa_d   = bus.a;
                    opb_d   = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                opa_d   = opa_q >> CHUNK;
                opb_d   = opb_q >> CHUNK;
                res_d   = (res_q >> CHUNK) | (WIDTH'(slice_sum) << (WIDTH - CHUNK));
                carry_d = slice_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    sum_d   = res_d;
                    cout_d  = slice_co;
                    ovf_d   = msb_ci ^ slice_co;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: covers WIDTH=16/CHUNK=4, WIDTH=8/CHUNK=8 and WIDTH=8/CHUNK=1,
// with a result scoreboard per instance.
`timescale 1ns/1ps

module tb_seq_chunk_adder;
    logic clock = 1'b0;
    logic resetn;

    always #5 clock = ~clock;

    seq_chunk_adder_if #(.WIDTH(16)) if16 ();
    seq_chunk_adder_if #(.WIDTH(8))  if88 ();
    seq_chunk_adder_if #(.WIDTH(8))  if81 ();

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u16 (.clock(clock), .resetn(resetn), .bus(if16));
    seq_chunk_adder #(.WIDTH(8),  .CHUNK(8)) u88 (.clock(clock), .resetn(resetn), .bus(if88));
    seq_chunk_adder #(.WIDTH(8),  .CHUNK(1)) u81 (.clock(clock), .resetn(resetn), .bus(if81));

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    exp_t q16[$];
    exp_t q88[$];
    exp_t q81[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] s, input logic c, input logic o);
        exp_t r;
        r.sum  = s;
        r.cout = c;
        r.ovf  = o;
        return r;
    endfunction

    // Reference result: full-width sum plus the sign rule for overflow.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        logic [15:0] mask, am, bb;
        logic [16:0] full;
        exp_t        r;
        mask   = (w == 16) ? 16'hFFFF : 16'h00FF;
        am     = a & mask;
        bb     = (sub ? ~b : b) & mask;
        full   = {1'b0, am} + {1'b0, bb} + {16'b0, (sub ? 1'b1 : cin)};
        r.sum  = full[15:0] & mask;
        r.cout = full[w];
        r.ovf  = (am[w-1] == bb[w-1]) && (r.sum[w-1] != am[w-1]);
        return r;
    endfunction

    // One clock; outputs are sampled on the falling edge and completed results are scored.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        if (if16.done) begin
            check("u16 done with pending op", 32'(q16.size() != 0), 32'd1);
            if (q16.size() != 0) begin
                e = q16.pop_front();
                check("u16 {ovf,cout,sum}", 32'({if16.overflow, if16.cout, if16.sum}),
                      32'({e.ovf, e.cout, e.sum}));
            end
        end
        if (if88.done) begin
            check("u88 done with pending op", 32'(q88.size() != 0), 32'd1);
            if (q88.size() != 0) begin
                e = q88.pop_front();
                check("u88 {ovf,cout,sum}", 32'({if88.overflow, if88.cout, if88.sum}),
                      32'({e.ovf, e.cout, e.sum[7:0]}));
            end
        end
        if (if81.done) begin
            check("u81 done with pending op", 32'(q81.size() != 0), 32'd1);
            if (q81.size() != 0) begin
                e = q81.pop_front();
                check("u81 {ovf,cout,sum}", 32'({if81.overflow, if81.cout, if81.sum}),
                      32'({e.ovf, e.cout, e.sum[7:0]}));
            end
        end
    endtask

    task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input logic sub, input bit push, input exp_t e);
        if16.a     = a;
        if16.b     = b;
        if16.cin   = cin;
        if16.sub   = sub;
        if16.start = 1'b1;
        if (push) q16.push_back(e);
        tick();
        if16.start = 1'b0;
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic sub, input exp_t e);
        if88.a = a;  if88.b = b;  if88.cin = cin;  if88.sub = sub;  if88.start = 1'b1;
        if81.a = a;  if81.b = b;  if81.cin = cin;  if81.sub = sub;  if81.start = 1'b1;
        q88.push_back(e);
        q81.push_back(e);
        tick();
        if88.start = 1'b0;
        if81.start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((q16.size() + q88.size() + q81.size()) != 0 && n < bound) begin
            tick();
            n++;
        end
        check("ops still pending after bound", 32'(q16.size() + q88.size() + q81.size()), 32'd0);
        q16.delete();
        q88.delete();
        q81.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[10];
        logic [15:0] ra, rb;
        logic        rc, rs;
        int          ndone;

        tbl[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[9] = '{1'b1, 16'h0000, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b1};

        if16.start = 1'b0; if16.sub = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0;
        if88.start = 1'b0; if88.sub = 1'b0; if88.a = '0; if88.b = '0; if88.cin = 1'b0;
        if81.start = 1'b0; if81.sub = 1'b0; if81.a = '0; if81.b = '0; if81.cin = 1'b0;

        resetn = 1'b1;
        #2 resetn = 1'b0;
        #20;
        check("reset busy", 32'(if16.busy), 32'd0);
        check("reset done", 32'(if16.done), 32'd0);
        check("reset {ovf,cout,sum}", 32'({if16.overflow, if16.cout, if16.sum}), 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        // Latency: start accepted at edge k, done after edge k+4.
        drive16(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, mk(16'h5555, 1'b0, 1'b0));
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("busy after k+%0d", i), 32'(if16.busy), 32'd1);
            check($sformatf("done after k+%0d", i), 32'(if16.done), 32'd0);
        end
        tick();
        check("done after k+4", 32'(if16.done), 32'd1);
        check("busy after k+4", 32'(if16.busy), 32'd0);
        tick();
        check("done is a single pulse", 32'(if16.done), 32'd0);

        for (int i = 0; i < 10; i++) begin
            drive16(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1'b1,
                    mk(tbl[i].sum, tbl[i].cout, tbl[i].ovf));
            wait_idle(12);
        end

        // Start while busy is dropped; start in the done cycle is taken.
        drive16(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, mk(16'h5555, 1'b0, 1'b0));
        tick();
        drive16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, mk(16'h0, 1'b0, 1'b0));
        tick();
        tick();
        check("first done despite ignored start", 32'(if16.done), 32'd1);
        drive16(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1, mk(16'h0003, 1'b0, 1'b0));
        check("sum held after back-to-back accept", 32'(if16.sum), 32'h5555);
        check("no done after back-to-back accept", 32'(if16.done), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("sum held m+%0d", i), 32'(if16.sum), 32'h5555);
        end
        tick();
        check("second done at m+4", 32'(if16.done), 32'd1);
        tick();

        // Leave a result with cout/overflow set, then abort the next op with reset.
        drive16(16'h8001, 16'h8000, 1'b0, 1'b0, 1'b1, mk(16'h0001, 1'b1, 1'b1));
        wait_idle(12);
        drive16(16'h00FF, 16'h0F0F, 1'b1, 1'b0, 1'b1, model(16, 16'h00FF, 16'h0F0F, 1'b1, 1'b0));
        tick();
        tick();
        check("busy before abort", 32'(if16.busy), 32'd1);
        resetn = 1'b0;
        #1;
        check("abort busy", 32'(if16.busy), 32'd0);
        check("abort done", 32'(if16.done), 32'd0);
        check("abort {ovf,cout,sum}", 32'({if16.overflow, if16.cout, if16.sum}), 32'd0);
        q16.delete();
        tick();
        resetn = 1'b1;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (if16.done) ndone++;
        end
        check("no done after abort", 32'(ndone), 32'd0);
        drive16(16'h0102, 16'h0304, 1'b0, 1'b0, 1'b1, mk(16'h0406, 1'b0, 1'b0));
        wait_idle(12);

        // WIDTH=8: CHUNK=8 completes after k+1, CHUNK=1 after k+8.
        drive8(8'hAB, 8'h55, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0));
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("u88 done after k+%0d", i), 32'(if88.done), 32'(i == 1));
            check($sformatf("u81 done after k+%0d", i), 32'(if81.done), 32'(i == 8));
        end
        wait_idle(4);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            drive16(ra, rb, rc, rs, 1'b1, model(16, ra, rb, rc, rs));
            wait_idle(12);
        end

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            rc = 1'($urandom);
            rs = 1'($urandom);
            drive8(ra[7:0], rb[7:0], rc, rs, model(8, ra, rb, rc, rs));
            wait_idle(20);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
